// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one single-port block DRAM between icache (port1, read) and dcache (port2, r/w).
// Latency: request edge to acknowledge is 2 cycles plus one per memory wait cycle; one transaction in flight.
// Backpressure: requests are held by the requesters until their one-cycle acknowledge; memory is held via mem_req until mem_ready.
module dram_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  dram_port1_request,
    input  logic [ADDR_W-1:0]                     dram_port1_address,
    output logic                                  dram_port1_acknowledge,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]    dram_port1_read_data,
    input  logic                                  dram_port2_request,
    input  logic [ADDR_W-1:0]                     dram_port2_address,
    input  logic                                  dram_port2_we,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]    dram_port2_write_data,
    output logic                                  dram_port2_acknowledge,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]    dram_port2_read_data,
    output logic                                  dram_busy,
    output logic                                  mem_req,
    output logic [ADDR_W-1:0]                     mem_address,
    output logic                                  mem_we,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]    mem_write_data,
    input  logic                                  mem_ready,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]    mem_read_data,
    output logic [CNT_W-1:0]                      port1_grants,
    output logic [CNT_W-1:0]                      port2_grants
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_nxt;
    logic   gnt2;
    logic   last2;
    logic   pick2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // On a tie, the port that did not win last time gets the grant.
    assign pick2 = dram_port2_request && (!dram_port1_request || !last2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt              = state;
        mem_req                = 1'b0;
        dram_busy              = 1'b0;
        dram_port1_acknowledge = 1'b0;
        dram_port2_acknowledge = 1'b0;
        case (state)
            IDLE: begin
                if (dram_port1_request || dram_port2_request) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                dram_busy = 1'b1;
                if (mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                dram_busy              = 1'b1;
                dram_port1_acknowledge = !gnt2;
                dram_port2_acknowledge = gnt2;
                state_nxt              = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt2                 <= 1'b0;
            last2                <= 1'b1;
            mem_address          <= '0;
            mem_we               <= 1'b0;
            mem_write_data       <= '0;
            dram_port1_read_data <= '0;
            dram_port2_read_data <= '0;
            port1_grants         <= '0;
            port2_grants         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dram_port1_request || dram_port2_request) begin
                        gnt2           <= pick2;
                        mem_address    <= pick2 ? dram_port2_address : dram_port1_address;
                        mem_we         <= pick2 && dram_port2_we;
                        mem_write_data <= pick2 ? dram_port2_write_data : '0;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        if (gnt2) begin
                            dram_port2_read_data <= mem_read_data;
                        end else begin
                            dram_port1_read_data <= mem_read_data;
                        end
                    end
                end
                RESP: begin
                    last2 <= gnt2;
                    if (gnt2) begin
                        if (!(&port2_grants)) port2_grants <= port2_grants + CNT_ONE;
                    end else begin
                        if (!(&port1_grants)) port1_grants <= port1_grants + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: table of request scenarios plus hand sequences, scoreboard of expected grants.
module tb_dram_port_arbiter;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [BW-1:0][WW-1:0] blk_t;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        we;
        blk_t        wdata;
    } txn_t;

    typedef struct {
        bit          rst;
        bit          p1;
        logic [31:0] a1;
        bit          p2;
        bit          we2;
        logic [31:0] a2;
        logic [31:0] wb;
        int          lat;
        int          first;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          dram_port1_request;
    logic [AW-1:0] dram_port1_address;
    logic          dram_port1_acknowledge;
    blk_t          dram_port1_read_data;
    logic          dram_port2_request;
    logic [AW-1:0] dram_port2_address;
    logic          dram_port2_we;
    blk_t          dram_port2_write_data;
    logic          dram_port2_acknowledge;
    blk_t          dram_port2_read_data;
    logic          dram_busy;
    logic          mem_req;
    logic [AW-1:0] mem_address;
    logic          mem_we;
    blk_t          mem_write_data;
    logic          mem_ready;
    blk_t          mem_read_data;
    logic [CW-1:0] port1_grants;
    logic [CW-1:0] port2_grants;

    dram_port_arbiter #(.ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .dram_port1_request(dram_port1_request), .dram_port1_address(dram_port1_address),
        .dram_port1_acknowledge(dram_port1_acknowledge), .dram_port1_read_data(dram_port1_read_data),
        .dram_port2_request(dram_port2_request), .dram_port2_address(dram_port2_address),
        .dram_port2_we(dram_port2_we), .dram_port2_write_data(dram_port2_write_data),
        .dram_port2_acknowledge(dram_port2_acknowledge), .dram_port2_read_data(dram_port2_read_data),
        .dram_busy(dram_busy), .mem_req(mem_req), .mem_address(mem_address), .mem_we(mem_we),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
        .port1_grants(port1_grants), .port2_grants(port2_grants)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int   total = 0;
    int   bad = 0;
    txn_t q1[$];
    txn_t q2[$];
    txn_t sb[$];
    int   last_m;
    int   cnt1_m;
    int   cnt2_m;
    blk_t rd1_m;
    blk_t rd2_m;
    int   mem_lat;
    vec_t vt[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic blk_t blk_of(input logic [31:0] a);
        blk_t b;
        for (int i = 0; i < BW; i++) b[i] = a - 32'h100 + i + 1;
        return b;
    endfunction

    function automatic blk_t wblk(input logic [31:0] base);
        blk_t b;
        for (int i = 0; i < BW; i++) b[i] = base + i;
        return b;
    endfunction

    function automatic blk_t junk();
        blk_t b;
        b = {$urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    task automatic drive_reqs();
        dram_port1_request    = 1'b0;
        dram_port1_address    = '0;
        dram_port2_request    = 1'b0;
        dram_port2_address    = '0;
        dram_port2_we         = 1'b0;
        dram_port2_write_data = '0;
        if (q1.size() != 0) begin
            dram_port1_request = 1'b1;
            dram_port1_address = q1[0].addr;
        end
        if (q2.size() != 0) begin
            dram_port2_request    = 1'b1;
            dram_port2_address    = q2[0].addr;
            dram_port2_we         = q2[0].we;
            dram_port2_write_data = q2[0].wdata;
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        sb.delete();
        last_m = 2;
        cnt1_m = 0;
        cnt2_m = 0;
        rd1_m  = '0;
        rd2_m  = '0;
    endtask

    task automatic push1(input logic [31:0] a);
        txn_t t;
        t.port = 1; t.addr = a; t.we = 1'b0; t.wdata = '0;
        q1.push_back(t);
    endtask

    task automatic push2(input logic [31:0] a, input logic we, input logic [31:0] wb);
        txn_t t;
        t.port = 2; t.addr = a; t.we = we; t.wdata = we ? wblk(wb) : '0;
        q2.push_back(t);
    endtask

    // Called on a falling edge with at least one request pending; returns at the following IDLE falling edge.
    task automatic serve_one(output int served, output int ack_cyc);
        txn_t e;
        txn_t got;
        int   w;
        served  = 0;
        ack_cyc = 0;
        if (q1.size() != 0 && q2.size() != 0) e = (last_m == 2) ? q1[0] : q2[0];
        else if (q1.size() != 0) e = q1[0];
        else e = q2[0];
        sb.push_back(e);
        w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (mem_req !== 1'b1) begin
            chk("mem_req_timeout", mem_req, 1);
            q1.delete(); q2.delete(); sb.delete();
            drive_reqs();
            return;
        end
        got = sb.pop_front();
        chk("mem_address", mem_address, got.addr);
        chk("mem_we", mem_we, got.we);
        chk("mem_write_data", mem_write_data, got.wdata);
        chk("busy_issue", dram_busy, 1);
        repeat (mem_lat) @(negedge clk);
        mem_ready     = 1'b1;
        mem_read_data = blk_of(got.addr);
        @(negedge clk);
        mem_ready     = 1'b0;
        mem_read_data = junk();
        served  = dram_port2_acknowledge ? 2 : (dram_port1_acknowledge ? 1 : 0);
        ack_cyc = cyc;
        chk("ack_port", served, got.port);
        chk("ack_both", dram_port1_acknowledge & dram_port2_acknowledge, 0);
        chk("mem_req_resp", mem_req, 0);
        if (got.port == 1) begin
            rd1_m = blk_of(got.addr);
            q1.delete(0);
            cnt1_m = (cnt1_m == CMAX) ? CMAX : cnt1_m + 1;
        end else begin
            rd2_m = blk_of(got.addr);
            q2.delete(0);
            cnt2_m = (cnt2_m == CMAX) ? CMAX : cnt2_m + 1;
        end
        chk("port1_read_data", dram_port1_read_data, rd1_m);
        chk("port2_read_data", dram_port2_read_data, rd2_m);
        last_m = got.port;
        drive_reqs();
        @(negedge clk);
        chk("port1_grants", port1_grants, cnt1_m);
        chk("port2_grants", port2_grants, cnt2_m);
        chk("ack_after_resp", dram_port1_acknowledge | dram_port2_acknowledge, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        drive_reqs();
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int s;
        int ac;
        int first;
        int g;
        int d;
        int order[6];

        vt[0] = '{0, 1, 32'h100, 0, 0, 32'h0,   32'h0,  3, 1};
        vt[1] = '{1, 1, 32'h140, 1, 1, 32'h200, 32'hA,  0, 1};
        vt[2] = '{0, 0, 32'h0,   1, 0, 32'h300, 32'h0,  1, 2};
        vt[3] = '{0, 1, 32'h400, 1, 1, 32'h480, 32'h10, 2, 1};
        vt[4] = '{0, 0, 32'h0,   1, 0, 32'h500, 32'h0,  0, 2};

        reset         = 1'b0;
        mem_ready     = 1'b0;
        mem_read_data = '0;
        mem_lat       = 0;
        model_reset();
        drive_reqs();
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", dram_busy, 0);
        chk("rst_acks", {dram_port1_acknowledge, dram_port2_acknowledge}, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_grants", {port1_grants, port2_grants}, 0);
        chk("rst_rd1", dram_port1_read_data, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].rst) do_reset();
            mem_lat = vt[i].lat;
            if (vt[i].p1) push1(vt[i].a1);
            if (vt[i].p2) push2(vt[i].a2, vt[i].we2, vt[i].wb);
            drive_reqs();
            first = -1;
            g = 0;
            while ((q1.size() != 0 || q2.size() != 0) && g < 4) begin
                serve_one(s, ac);
                if (first < 0) first = s;
                g++;
            end
            chk($sformatf("vec%0d_first", i), first, vt[i].first);
            chk($sformatf("vec%0d_busy_idle", i), dram_busy, 0);
        end

        mem_lat = 1;
        for (int k = 0; k < 3; k++) begin
            push1(32'h600 + 32'h40 * k);
            push2(32'h700 + 32'h40 * k, k[0], 32'h20 + k);
        end
        drive_reqs();
        for (int k = 0; k < 6; k++) begin
            serve_one(s, ac);
            order[k] = s;
        end
        for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], (k % 2 == 0) ? 1 : 2);
        chk("port1_saturated", port1_grants, CMAX);

        mem_ready     = 1'b1;
        mem_read_data = junk();
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("stray_acks", {dram_port1_acknowledge, dram_port2_acknowledge}, 0);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_busy", dram_busy, 0);
        mem_lat = 0;
        push2(32'h540, 1'b0, 32'h0);
        drive_reqs();
        d = cyc;
        serve_one(s, ac);
        chk("min_latency", ac - d, 2);

        push1(32'hA00);
        drive_reqs();
        g = 0;
        while (mem_req !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("midrst_issue", mem_req, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", dram_busy, 0);
        chk("midrst_acks", {dram_port1_acknowledge, dram_port2_acknowledge}, 0);
        chk("midrst_addr", mem_address, 0);
        chk("midrst_grants", {port1_grants, port2_grants}, 0);
        model_reset();
        drive_reqs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_replay", {mem_req, dram_port1_acknowledge, dram_port2_acknowledge}, 0);
        push2(32'h800, 1'b0, 32'h0);
        drive_reqs();
        serve_one(s, ac);
        chk("post_rst_port2", s, 2);
        push1(32'h900);
        push2(32'h940, 1'b1, 32'h30);
        drive_reqs();
        serve_one(s, ac);
        chk("post_rst_tie", s, 1);
        serve_one(s, ac);
        chk("post_rst_tie_second", s, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
